// File: rtl/tagged_stream_dispatcher.sv
// Tags an untagged beat stream per packet for the tagged crossbar: round-robin or explicit
// destination, tag held for a whole packet, one-slice registered output.
module tagged_stream_dispatcher #(
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned NUM_OUTPUTS = 4,
    parameter int unsigned TAG_WIDTH   = $clog2(NUM_OUTPUTS),
    parameter int unsigned MODE        = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_OUTPUTS-1:0] cfg_dest_mask,
    input  logic [TAG_WIDTH-1:0]   sel_tag,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [KEEP_WIDTH-1:0]  in_keep,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic [KEEP_WIDTH-1:0]  out_keep,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            pkt_count,
    output logic [31:0]            drop_count
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t               state, state_nx;
    logic [TAG_WIDTH-1:0] cur_tag, cur_tag_nx;
    logic [TAG_WIDTH-1:0] rr_ptr, rr_ptr_nx;
    logic [TAG_WIDTH-1:0] pick, idle_tag, beat_tag;
    logic                 pick_ok, sel_ok, idle_ok;
    logic                 slot_free, fwd_beat, pkt_end, drop_end;

    function automatic logic [TAG_WIDTH-1:0] next_ptr(input logic [TAG_WIDTH-1:0] t);
        if (32'(t) + 32'd1 >= NUM_OUTPUTS) return '0;
        return t + TAG_WIDTH'(1);
    endfunction

    assign slot_free = !out_valid || out_ready;

    // First enabled destination at or after rr_ptr, wrapping circularly
    always_comb begin
        int unsigned pos;
        logic        hit;
        pick    = '0;
        pick_ok = 1'b0;
        pos     = 0;
        hit     = 1'b0;
        for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            pos = 32'(rr_ptr) + i;
            if (pos >= NUM_OUTPUTS) pos = pos - NUM_OUTPUTS;
            hit = 1'b0;
            for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
                if (j == pos) hit = cfg_dest_mask[j];
            end
            if (!pick_ok && hit) begin
                pick    = TAG_WIDTH'(pos);
                pick_ok = 1'b1;
            end
        end
    end

    // Explicit tag is usable only if in range and enabled
    always_comb begin
        sel_ok = 1'b0;
        for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            if (sel_tag == TAG_WIDTH'(i) && cfg_dest_mask[i]) sel_ok = 1'b1;
        end
    end

    assign idle_tag = (MODE == 0) ? pick : sel_tag;
    assign idle_ok  = (MODE == 0) ? pick_ok : sel_ok;

    // Next-state, handshake and bookkeeping strobes
    always_comb begin
        state_nx   = state;
        cur_tag_nx = cur_tag;
        rr_ptr_nx  = rr_ptr;
        in_ready   = 1'b0;
        fwd_beat   = 1'b0;
        pkt_end    = 1'b0;
        drop_end   = 1'b0;
        beat_tag   = cur_tag;
        case (state)
            IDLE: begin
                if (idle_ok) begin
                    in_ready = slot_free;
                    fwd_beat = in_valid && slot_free;
                    beat_tag = idle_tag;
                    if (fwd_beat) begin
                        if (in_last) begin
                            pkt_end = 1'b1;
                            if (MODE == 0) rr_ptr_nx = next_ptr(idle_tag);
                        end else begin
                            state_nx   = FWD;
                            cur_tag_nx = idle_tag;
                        end
                    end
                end else if (MODE != 0) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        if (in_last) drop_end = 1'b1;
                        else         state_nx = DROP;
                    end
                end
            end
            FWD: begin
                in_ready = slot_free;
                fwd_beat = in_valid && slot_free;
                if (fwd_beat && in_last) begin
                    state_nx = IDLE;
                    pkt_end  = 1'b1;
                    if (MODE == 0) rr_ptr_nx = next_ptr(cur_tag);
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_nx = IDLE;
                    drop_end = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rst) in_ready = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_tag <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nx;
            cur_tag <= cur_tag_nx;
            rr_ptr  <= rr_ptr_nx;
        end
    end

    // Output slice: loads only when the slot is free, so fields hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (fwd_beat) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_tag   <= beat_tag;
            out_keep  <= in_keep;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (pkt_end)  pkt_count  <= pkt_count + 32'd1;
            if (drop_end) drop_count <= drop_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_tagged_stream_dispatcher.sv
// Randomized bench for tagged_stream_dispatcher: a mode-0 and a mode-1 instance share stimulus;
// a packet-level reference model predicts every output beat, in_ready and the counters.
module tb_tagged_stream_dispatcher;

    localparam int unsigned DW = 32;
    localparam int unsigned KW = 4;
    localparam int unsigned NO = 4;
    localparam int unsigned TW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NO-1:0] cfg_dest_mask = 4'hF;
    logic [TW-1:0] sel_tag = '0;
    logic [DW-1:0] in_data = '0;
    logic [KW-1:0] in_keep = '0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;

    logic          r0_in_ready, r0_out_last, r0_out_valid;
    logic [DW-1:0] r0_out_data;
    logic [TW-1:0] r0_out_tag;
    logic [KW-1:0] r0_out_keep;
    logic [31:0]   r0_pkt, r0_drop;
    logic          r1_in_ready, r1_out_last, r1_out_valid;
    logic [DW-1:0] r1_out_data;
    logic [TW-1:0] r1_out_tag;
    logic [KW-1:0] r1_out_keep;
    logic [31:0]   r1_pkt, r1_drop;

    logic          o_in_ready, o_out_last, o_out_valid;
    logic [DW-1:0] o_out_data;
    logic [TW-1:0] o_out_tag;
    logic [KW-1:0] o_out_keep;
    logic [31:0]   o_pkt, o_drop;

    int m = 0;
    int rdy_pct = 100;
    int n_tests = 0;
    int n_fail = 0;

    tagged_stream_dispatcher #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_OUTPUTS(NO), .TAG_WIDTH(TW), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .cfg_dest_mask(cfg_dest_mask), .sel_tag(sel_tag),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .in_valid(in_valid), .in_ready(r0_in_ready),
        .out_data(r0_out_data), .out_tag(r0_out_tag), .out_keep(r0_out_keep), .out_last(r0_out_last),
        .out_valid(r0_out_valid), .out_ready(out_ready), .pkt_count(r0_pkt), .drop_count(r0_drop));

    tagged_stream_dispatcher #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_OUTPUTS(NO), .TAG_WIDTH(TW), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .cfg_dest_mask(cfg_dest_mask), .sel_tag(sel_tag),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .in_valid(in_valid), .in_ready(r1_in_ready),
        .out_data(r1_out_data), .out_tag(r1_out_tag), .out_keep(r1_out_keep), .out_last(r1_out_last),
        .out_valid(r1_out_valid), .out_ready(out_ready), .pkt_count(r1_pkt), .drop_count(r1_drop));

    always_comb begin
        o_in_ready  = (m != 0) ? r1_in_ready  : r0_in_ready;
        o_out_data  = (m != 0) ? r1_out_data  : r0_out_data;
        o_out_tag   = (m != 0) ? r1_out_tag   : r0_out_tag;
        o_out_keep  = (m != 0) ? r1_out_keep  : r0_out_keep;
        o_out_last  = (m != 0) ? r1_out_last  : r0_out_last;
        o_out_valid = (m != 0) ? r1_out_valid : r0_out_valid;
        o_pkt       = (m != 0) ? r1_pkt       : r0_pkt;
        o_drop      = (m != 0) ? r1_drop      : r0_drop;
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state: packet-level view of the dispatcher
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [TW-1:0] t;
    } beat_t;

    beat_t       exp_q[$];
    int          seen_tags[$];
    bit          mdl_in_pkt, mdl_drop;
    int          mdl_tag, mdl_rr;
    int unsigned mdl_pkts, mdl_drops;
    bit          hold_v;
    logic [39:0] hold_f;

    function automatic bit sel_valid();
        int s = int'(sel_tag);
        if (s >= int'(NO)) return 1'b0;
        return cfg_dest_mask[s];
    endfunction

    task automatic push_beat(input int tag);
        beat_t b;
        b.d = in_data; b.k = in_keep; b.l = in_last; b.t = TW'(tag);
        exp_q.push_back(b);
    endtask

    task automatic end_pkt(input int tag);
        mdl_pkts++;
        if (m == 0) mdl_rr = (tag + 1) % int'(NO);
    endtask

    task automatic model_accept();
        bit ok = 1'b0;
        int tag = 0;
        if (!mdl_in_pkt) begin
            if (m == 0) begin
                for (int i = 0; i < int'(NO); i++) begin
                    int d = (mdl_rr + i) % int'(NO);
                    if (!ok && cfg_dest_mask[d]) begin ok = 1'b1; tag = d; end
                end
            end else if (sel_valid()) begin
                ok = 1'b1; tag = int'(sel_tag);
            end
            if (!ok) begin
                if (in_last) mdl_drops++;
                else begin mdl_in_pkt = 1'b1; mdl_drop = 1'b1; end
            end else begin
                push_beat(tag);
                if (in_last) end_pkt(tag);
                else begin mdl_in_pkt = 1'b1; mdl_drop = 1'b0; mdl_tag = tag; end
            end
        end else if (mdl_drop) begin
            if (in_last) begin mdl_drops++; mdl_in_pkt = 1'b0; end
        end else begin
            push_beat(mdl_tag);
            if (in_last) begin end_pkt(mdl_tag); mdl_in_pkt = 1'b0; end
        end
    endtask

    // Monitor: samples mid-cycle, i.e. the values seen by the coming rising edge
    always @(negedge clk) begin
        logic  sf;
        logic  exp_rdy;
        beat_t e;
        if (rst) begin
            exp_q.delete();
            mdl_in_pkt = 1'b0; mdl_drop = 1'b0; mdl_tag = 0; mdl_rr = 0;
            mdl_pkts = 0; mdl_drops = 0; hold_v = 1'b0;
        end else begin
            sf = !o_out_valid || out_ready;
            if (!mdl_in_pkt) begin
                if (m == 0) exp_rdy = (|cfg_dest_mask) && sf;
                else        exp_rdy = sel_valid() ? sf : 1'b1;
            end else begin
                exp_rdy = mdl_drop ? 1'b1 : sf;
            end
            chk("in_ready", 64'(o_in_ready), 64'(exp_rdy));
            if (hold_v) begin
                chk("stall_valid", 64'(o_out_valid), 64'd1);
                chk("stall_fields", 64'({o_out_data, o_out_keep, o_out_last, o_out_tag}), 64'(hold_f));
            end
            hold_v = o_out_valid && !out_ready;
            hold_f = {o_out_data, o_out_keep, o_out_last, o_out_tag};
            if (o_out_valid && out_ready) begin
                seen_tags.push_back(int'(o_out_tag));
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", 64'({o_out_data, o_out_keep, o_out_last, o_out_tag}), 64'({e.d, e.k, e.l, e.t}));
                end
            end
            if (in_valid && o_in_ready) model_accept();
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Entry and exit points of stimulus tasks are 1 time unit after a rising edge
    task automatic wait_accept();
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (o_in_ready) break;
            if (n > 500) begin chk("accept_timeout", 64'd0, 64'd1); break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic last);
        in_valid = 1'b1;
        in_data  = $urandom;
        in_keep  = KW'($urandom);
        in_last  = last;
        wait_accept();
    endtask

    task automatic send_pkt(input int len);
        for (int i = 0; i < len; i++) drive_beat(i == len - 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 2000 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_pkt"}, 64'(o_pkt), 64'(mdl_pkts));
        chk({tag, "_drop"}, 64'(o_drop), 64'(mdl_drops));
    endtask

    int exp_t1[6] = '{0, 1, 2, 3, 0, 1};
    int exp_t2[9] = '{1, 1, 1, 3, 3, 3, 1, 1, 1};

    initial begin
        int base, beats;
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", 64'(o_out_valid), 64'd0);
        chk("rst_out_fields", 64'({o_out_data, o_out_keep, o_out_last, o_out_tag}), 64'd0);
        chk("rst_in_ready", 64'(o_in_ready), 64'd0);
        chk("rst_pkt", 64'(o_pkt), 64'd0);
        chk("rst_drop", 64'(o_drop), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Round-robin over full mask, single-beat packets back to back
        base = seen_tags.size();
        for (int i = 0; i < 6; i++) send_pkt(1);
        drain();
        chk("t1_count", 64'(seen_tags.size() - base), 64'd6);
        for (int i = 0; i < 6 && base + i < seen_tags.size(); i++)
            chk("t1_tag", 64'(seen_tags[base + i]), 64'(exp_t1[i]));
        chk("t1_pkt", 64'(o_pkt), 64'd6);

        // Sparse mask; mask change mid-packet must not retag that packet
        do_reset();
        cfg_dest_mask = 4'b1010;
        base = seen_tags.size();
        send_pkt(3);
        drive_beat(1'b0);
        cfg_dest_mask = 4'b0001;
        drive_beat(1'b0);
        drive_beat(1'b1);
        cfg_dest_mask = 4'b1010;
        send_pkt(3);
        drain();
        chk("t2_count", 64'(seen_tags.size() - base), 64'd9);
        for (int i = 0; i < 9 && base + i < seen_tags.size(); i++)
            chk("t2_tag", 64'(seen_tags[base + i]), 64'(exp_t2[i]));
        chk_counts("t2");

        // Empty mask stalls; enabling destination 2 releases the held beat
        do_reset();
        cfg_dest_mask = 4'b0000;
        in_valid = 1'b1; in_data = $urandom; in_keep = KW'($urandom); in_last = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("t3_stall", 64'(o_in_ready), 64'd0);
        end
        @(posedge clk); #1;
        cfg_dest_mask = 4'b0100;
        wait_accept();
        drain();
        chk("t3_tag", 64'(seen_tags[seen_tags.size() - 1]), 64'd2);
        chk_counts("t3");

        // Explicit tags: out-of-range tag drops a packet, valid tag forwards
        m = 1;
        do_reset();
        cfg_dest_mask = 4'hF;
        base = seen_tags.size();
        sel_tag = 3'd5;
        send_pkt(4);
        sel_tag = 3'd2;
        send_pkt(2);
        drain();
        chk("t4_count", 64'(seen_tags.size() - base), 64'd2);
        for (int i = base; i < seen_tags.size(); i++) chk("t4_tag", 64'(seen_tags[i]), 64'd2);
        chk("t4_drop", 64'(o_drop), 64'd1);
        chk("t4_pkt", 64'(o_pkt), 64'd1);

        // Random traffic under 30% output readiness, both modes
        m = 0;
        do_reset();
        rdy_pct = 30;
        beats = 0;
        while (beats < 200) begin
            int len = $urandom_range(1, 4);
            cfg_dest_mask = NO'($urandom_range(1, 15));
            sel_tag = TW'($urandom);
            send_pkt(len);
            beats += len;
        end
        drain();
        chk_counts("t5_m0");
        m = 1;
        do_reset();
        beats = 0;
        while (beats < 150) begin
            int len = $urandom_range(1, 4);
            cfg_dest_mask = NO'($urandom_range(0, 15));
            sel_tag = TW'($urandom);
            send_pkt(len);
            beats += len;
        end
        drain();
        chk_counts("t5_m1");

        // Reset mid-packet: everything clears, next packet restarts round-robin at 0
        m = 0;
        rdy_pct = 100;
        cfg_dest_mask = 4'hF;
        do_reset();
        send_pkt(1);
        drive_beat(1'b0);
        in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t6_out_valid", 64'(o_out_valid), 64'd0);
        chk("t6_pkt", 64'(o_pkt), 64'd0);
        chk("t6_drop", 64'(o_drop), 64'd0);
        chk("t6_in_ready", 64'(o_in_ready), 64'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send_pkt(1);
        drain();
        chk("t6_tag", 64'(seen_tags[seen_tags.size() - 1]), 64'd0);
        chk("t6_pkt_after", 64'(o_pkt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
